fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, instruction buffer entries (power of two, >=2).
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0000, word presented when buffer empty.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  permits issuing new fetch requests.
REQ-007 SHALL have port stall  input  1  decode not accepting; head held.
REQ-008 SHALL have port redirect_valid  input  1  taken branch/PC write from writeback.
REQ-009 SHALL have port redirect_pc  input  32  new fetch address.
REQ-010 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-011 SHALL have port imem_req_ready  input  1  instruction memory accepts request.
REQ-012 SHALL have port imem_addr  output  32  fetch address, word aligned.
REQ-013 SHALL have port imem_rsp_valid  input  1  instruction word returned, in request order.
REQ-014 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-015 SHALL have port instructionD  output  32  instruction to decode stage.
REQ-016 SHALL have port pc  output  32  address of instructionD.
REQ-017 SHALL have port instr_valid  output  1  instructionD/pc hold a real instruction.

Function
REQ-018 SHALL implement states IDLE, FETCH, DRAIN; IDLE->FETCH when enable=1; FETCH->IDLE when enable=0 and no redirect.
REQ-019 SHALL assert imem_req_valid only in FETCH and only when occupancy+inflight < FIFO_DEPTH.
REQ-020 SHALL treat a request as accepted when imem_req_valid & imem_req_ready; fetch_pc then advances by 4, wrapping 32'hFFFF_FFFC->0.
REQ-021 SHALL hold imem_addr and imem_req_valid stable while imem_req_valid & !imem_req_ready, unless redirect_valid.
REQ-022 SHALL push {fetch address, imem_rsp_data} into the buffer on each imem_rsp_valid with drop_count=0; inflight decrements on every response.
REQ-023 SHALL drive instructionD/pc from buffer head with instr_valid=1 when non-empty; else NOP_INSTR, 32'h0, 0.
REQ-024 SHALL pop head when instr_valid & !stall; pop and push in same cycle leave occupancy unchanged.
REQ-025 SHALL on redirect_valid: flush buffer, set fetch_pc=redirect_pc, set drop_count=inflight (after same-cycle accept/response), go DRAIN if that is non-zero else FETCH (IDLE if enable=0).
REQ-026 SHALL in DRAIN issue no requests, discard responses decrementing drop_count, and enter FETCH in the cycle after drop_count reaches 0.
REQ-027 SHALL give redirect priority over pop, push and accept in the same cycle; a new redirect in DRAIN updates fetch_pc and drop_count as REQ-025.
REQ-028 SHALL ignore redirect_pc[1:0] (forced to 0).
REQ-029 SHALL have minimum latency response-to-instr_valid of 1 cycle (registered buffer).

Reset
REQ-030 SHALL on rst=0 immediately set state=IDLE, fetch_pc=RESET_PC, occupancy=inflight=drop_count=0.
REQ-031 SHALL during reset drive imem_req_valid=0, instr_valid=0, instructionD=NOP_INSTR, pc=0; reset mid-fetch abandons in-flight requests.

Structure
REQ-032 SHALL take state enum, NOP default and buffer-entry struct {pc, instr} from shared package fetch_pkg.
REQ-033 SHALL instantiate one sub-module fetch_fifo (parameterised depth, push/pop/flush, full/empty, count).

Verification
REQ-034 SHALL test: reset release, enable=1, ready=1, 1-cycle memory -> addrs 0,4,8,12; instr_valid first on cycle 3 with pc=0.
REQ-035 SHALL test: stall=1 for 10 cycles -> exactly 4 requests issued, head stays pc=0, no requests while full.
REQ-036 SHALL test: redirect_pc=32'h100 with 2 inflight -> both responses dropped, next instr_valid shows pc=32'h100.
REQ-037 SHALL test: fetch_pc=32'hFFFF_FFF8, two accepts -> addrs FFFF_FFF8, FFFF_FFFC, then 0.
REQ-038 SHALL test: imem_req_ready=0 for 3 cycles -> imem_addr constant, one push per accepted request.
REQ-039 SHALL test: rst=0 asserted mid-DRAIN -> outputs at reset values same cycle, refetch from RESET_PC after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, the default
// bubble word and the instruction buffer entry.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Word shown to decode when nothing real is buffered.
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two circular FIFO of {pc, instr} entries with
// a synchronous flush. Push into a full buffer is accepted only alongside a pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             wdata_i,
  input  logic                     pop_i,
  output fetch_entry_t             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array: written at the tail, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and occupancy; flush wins over any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers in-order
// responses and presents them to decode. Redirects flush the buffer and
// discard responses still owed for the old path (DRAIN).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instructionD,
  output logic [31:0] pc,
  output logic        instr_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;   // address owed to the next kept response
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;

  fetch_entry_t  head, wentry;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [SW-1:0] occ_sum;
  logic          accept, push, pop;
  logic [31:0]   redir_pc_aligned;

  assign redir_pc_aligned = redirect_pc & ~32'h3;
  assign occ_sum          = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign imem_req_valid   = (state_q == FETCH) && (occ_sum < SW'(FIFO_DEPTH));
  assign imem_addr        = fetch_pc_q;
  assign accept           = imem_req_valid & imem_req_ready;

  // Responses arrive in request order, so the owed address is a running pc.
  assign wentry.pc    = rsp_pc_q;
  assign wentry.instr = imem_rsp_data;
  assign push = imem_rsp_valid & (drop_q == '0) & ~redirect_valid & (~fifo_full | pop);
  assign pop  = ~fifo_empty & ~stall & ~redirect_valid;

  assign instr_valid  = ~fifo_empty;
  assign instructionD = fifo_empty ? NOP_INSTR : head.instr;
  assign pc           = fifo_empty ? 32'h0 : head.pc;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state: request/response bookkeeping, then FSM, then redirect override.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CW'(accept) - CW'(imem_rsp_valid);

    if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
    if (push)   rsp_pc_d   = rsp_pc_q + 32'd4;
    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;

    case (state_q)
      IDLE:  if (enable) state_d = FETCH;
      // Leave only once no request is parked waiting on ready.
      FETCH: if (!enable && !(imem_req_valid && !imem_req_ready)) state_d = IDLE;
      DRAIN: if (drop_d == '0) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    // Everything still owed by memory (including this cycle's accept) is stale.
    if (redirect_valid) begin
      fetch_pc_d = redir_pc_aligned;
      rsp_pc_d   = redir_pc_aligned;
      drop_d     = inflight_d;
      if (inflight_d != '0) state_d = DRAIN;
      else                  state_d = enable ? FETCH : IDLE;
    end
  end

  // State registers; reset abandons anything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC & ~32'h3;
      rsp_pc_q   <= RESET_PC & ~32'h3;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle in-order memory model that
// can be told to hold its responses.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, enable, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instructionD, pc;
  logic        instr_valid;

  int vecs = 0;
  int errs = 0;

  logic [31:0] mq[$];
  int          acc_cnt = 0;
  int          base;
  logic        mem_hold = 1'b0;
  logic        m_acc;
  logic [31:0] m_addr;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instructionD   (instructionD),
    .pc             (pc),
    .instr_valid    (instr_valid)
  );

  always #5 clk = ~clk;

  // Memory: a request accepted at an edge is answered during the next cycle
  // with data = ~address, unless mem_hold parks the queue.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      m_acc  = rst & imem_req_valid & imem_req_ready;
      m_addr = imem_addr;
      @(posedge clk);
      #1;
      if (!rst) begin
        mq.delete();
        imem_rsp_valid = 1'b0;
      end else begin
        if (m_acc) begin
          mq.push_back(m_addr);
          acc_cnt++;
        end
        if (!mem_hold && mq.size() > 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = ~mq.pop_front();
        end else begin
          imem_rsp_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rst_chk();
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instrD", instructionD, 32'h0);
    chk("rst_pc", pc, 32'h0);
  endtask

  // Assert reset mid-cycle, check outputs right away, hold for two edges.
  task automatic apply_reset();
    rst = 1'b0;
    #1;
    rst_chk();
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_req_ready = 1'b1;
    #1;
    rst_chk();
    tick(); tick();

    // Basic streaming: addresses 0,4,8,12, first instruction on 3rd cycle.
    enable = 1'b1; rst = 1'b1;
    tick();
    chk("t1_e1_req", 32'(imem_req_valid), 32'h1);
    chk("t1_e1_addr", imem_addr, 32'h0);
    chk("t1_e1_iv", 32'(instr_valid), 32'h0);
    tick();
    chk("t1_e2_addr", imem_addr, 32'h4);
    chk("t1_e2_iv", 32'(instr_valid), 32'h0);
    tick();
    chk("t1_e3_iv", 32'(instr_valid), 32'h1);
    chk("t1_e3_pc", pc, 32'h0);
    chk("t1_e3_instr", instructionD, 32'hFFFF_FFFF);
    chk("t1_e3_addr", imem_addr, 32'h8);
    tick();
    chk("t1_e4_pc", pc, 32'h4);
    chk("t1_e4_instr", instructionD, 32'hFFFF_FFFB);
    chk("t1_e4_addr", imem_addr, 32'hC);

    // Stall: buffer fills with exactly FIFO_DEPTH requests, head pinned.
    apply_reset();
    stall = 1'b1; enable = 1'b1; rst = 1'b1;
    base = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_head_pc", pc, 32'h0);
      if (i >= 4) chk("t2_no_req_full", 32'(imem_req_valid), 32'h0);
    end
    chk("t2_req_count", 32'(acc_cnt - base), 32'd4);
    chk("t2_iv", 32'(instr_valid), 32'h1);
    chk("t2_instr", instructionD, 32'hFFFF_FFFF);
    stall = 1'b0;
    tick();
    chk("t2_pop_pc", pc, 32'h4);
    chk("t2_resume_req", 32'(imem_req_valid), 32'h1);
    chk("t2_resume_addr", imem_addr, 32'h10);

    // Redirect with two responses outstanding: both discarded.
    apply_reset();
    enable = 1'b1; stall = 1'b1; mem_hold = 1'b1; rst = 1'b1;
    tick(); tick(); tick();
    chk("t3_pre_addr", imem_addr, 32'h8);
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1; mem_hold = 1'b0;
    chk("t3_drain_req0", 32'(imem_req_valid), 32'h0);
    tick();
    chk("t3_drain_req1", 32'(imem_req_valid), 32'h0);
    chk("t3_drain_iv1", 32'(instr_valid), 32'h0);
    tick();
    chk("t3_drain_req2", 32'(imem_req_valid), 32'h0);
    chk("t3_drain_iv2", 32'(instr_valid), 32'h0);
    tick();
    chk("t3_refetch_req", 32'(imem_req_valid), 32'h1);
    chk("t3_refetch_addr", imem_addr, 32'h100);
    chk("t3_refetch_iv", 32'(instr_valid), 32'h0);
    tick();
    chk("t3_wait_iv", 32'(instr_valid), 32'h0);
    tick();
    chk("t3_new_iv", 32'(instr_valid), 32'h1);
    chk("t3_new_pc", pc, 32'h100);
    chk("t3_new_instr", instructionD, 32'hFFFF_FEFF);

    // Address wrap; low redirect bits ignored.
    apply_reset();
    enable = 1'b1; stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFB;
    rst = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("t4_req", 32'(imem_req_valid), 32'h1);
    chk("t4_addr0", imem_addr, 32'hFFFF_FFF8);
    tick();
    chk("t4_addr1", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t4_addr2", imem_addr, 32'h0);
    chk("t4_pc0", pc, 32'hFFFF_FFF8);
    tick();
    chk("t4_addr3", imem_addr, 32'h4);
    chk("t4_pc1", pc, 32'hFFFF_FFFC);

    // Memory not ready for 3 cycles: request held, one push per accept.
    imem_req_ready = 1'b0;
    tick();
    chk("t5_hold_addr0", imem_addr, 32'h4);
    chk("t5_pc0", pc, 32'h0);
    tick();
    chk("t5_hold_addr1", imem_addr, 32'h4);
    chk("t5_empty", 32'(instr_valid), 32'h0);
    tick();
    chk("t5_hold_addr2", imem_addr, 32'h4);
    chk("t5_hold_req", 32'(imem_req_valid), 32'h1);
    imem_req_ready = 1'b1;
    tick();
    chk("t5_adv_addr", imem_addr, 32'h8);
    tick();
    chk("t5_pc4", pc, 32'h4);
    chk("t5_instr4", instructionD, 32'hFFFF_FFFB);
    tick();
    chk("t5_pc8", pc, 32'h8);

    // Reset in the middle of DRAIN: refetch from RESET_PC, stale data gone.
    apply_reset();
    enable = 1'b1; stall = 1'b0; mem_hold = 1'b1; rst = 1'b1;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("t6_drain_req0", 32'(imem_req_valid), 32'h0);
    tick();
    chk("t6_drain_req1", 32'(imem_req_valid), 32'h0);
    apply_reset();
    mem_hold = 1'b0; rst = 1'b1;
    tick();
    chk("t6_req", 32'(imem_req_valid), 32'h1);
    chk("t6_addr", imem_addr, 32'h0);
    tick();
    chk("t6_iv0", 32'(instr_valid), 32'h0);
    tick();
    chk("t6_iv1", 32'(instr_valid), 32'h1);
    chk("t6_pc", pc, 32'h0);
    chk("t6_instr", instructionD, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
